// File: rtl/two_four_monitor_pkg.sv
// Shared constants, types and the BCD increment helper for the 2/4 counter monitor.
// Optional macro TWO_FOUR_MONITOR_HOLD_EN (display hold) is handled in the top module.
package two_four_pkg;

   localparam int NUM_DIGITS   = 4;
   localparam int TALLY_DIGITS = 2;

   localparam logic [6:0]            SEG_BLANK = 7'h7F;
   localparam logic [NUM_DIGITS-1:0] AN_OFF    = 4'hF;

   // Active-low {g,f,e,d,c,b,a} patterns for hex digits 0..F
   localparam logic [6:0] SEG_TABLE [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

   typedef logic [3:0] bcd_t;
   typedef logic [1:0] digit_idx_t;

   function automatic logic [4*TALLY_DIGITS-1:0] bcd_inc(input logic [4*TALLY_DIGITS-1:0] v);
      bcd_t ones;
      bcd_t tens;
      ones = v[3:0];
      tens = v[7:4];
      if (ones == 4'd9) begin
         ones = 4'd0;
         if (tens == 4'd9) begin
            tens = 4'd0;
         end else begin
            tens = tens + 4'd1;
         end
      end else begin
         ones = ones + 4'd1;
      end
      return {tens, ones};
   endfunction

endpackage

// File: rtl/two_four_monitor_hex_to_seg.sv
// Combinational hex digit to active-low seven-segment decoder.
module hex_to_seg
   import two_four_pkg::*;
(
   input  logic [3:0] val,
   output logic [6:0] seg
);

   assign seg = SEG_TABLE[val];

endmodule

// File: rtl/two_four_monitor.sv
// Counts rising edges of z as a 2-digit BCD tally, latches {a,b,c,d} per event and
// scans a 4-digit common-anode display. Define TWO_FOUR_MONITOR_HOLD_EN for a display-hold input.
module two_four_monitor
   import two_four_pkg::*;
#(
   parameter int unsigned SCAN_DIV = 4
)
(
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       a,
   input  logic                       b,
   input  logic                       c,
   input  logic                       d,
   input  logic                       x,
   input  logic                       z,
   input  logic                       clr,
`ifdef TWO_FOUR_MONITOR_HOLD_EN
   input  logic                       hold,
`endif
   output logic [4*TALLY_DIGITS-1:0]  tally,
   output logic [3:0]                 last_state,
   output logic                       event_pulse,
   output logic [6:0]                 seg,
   output logic [NUM_DIGITS-1:0]      an
);

   localparam logic [15:0] SCAN_TERM = 16'(SCAN_DIV - 1);

   logic                      z_d_r;
   logic                      edge_s;
   logic                      event_pulse_r;
   logic [4*TALLY_DIGITS-1:0] tally_r;
   logic [3:0]                last_state_r;
   logic [15:0]               presc_r;
   digit_idx_t                idx_r;
   logic [6:0]                seg_r;
   logic [NUM_DIGITS-1:0]     an_r;
   logic [4*TALLY_DIGITS-1:0] disp_tally_s;
   logic [3:0]                disp_state_s;
   logic                      disp_x_s;
   bcd_t                      digit_s;
   logic [6:0]                dec_seg_s;

   assign edge_s = z & ~z_d_r;

   // Edge history, event tally, state latch and event strobe; clr outranks a coincident edge
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         z_d_r         <= 1'b1;
         tally_r       <= 8'h00;
         last_state_r  <= 4'h0;
         event_pulse_r <= 1'b0;
      end else begin
         z_d_r <= z;
         if (clr) begin
            tally_r       <= 8'h00;
            last_state_r  <= 4'h0;
            event_pulse_r <= 1'b0;
         end else if (edge_s) begin
            tally_r       <= bcd_inc(tally_r);
            last_state_r  <= {a, b, c, d};
            event_pulse_r <= 1'b1;
         end else begin
            event_pulse_r <= 1'b0;
         end
      end
   end

`ifdef TWO_FOUR_MONITOR_HOLD_EN
   logic                      hold_d_r;
   logic [4*TALLY_DIGITS-1:0] tally_snap_r;
   logic [3:0]                state_snap_r;
   logic                      x_snap_r;

   // Snapshot of the displayed values taken on the cycle hold rises
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         hold_d_r     <= 1'b0;
         tally_snap_r <= 8'h00;
         state_snap_r <= 4'h0;
         x_snap_r     <= 1'b0;
      end else begin
         hold_d_r <= hold;
         if (hold & ~hold_d_r) begin
            tally_snap_r <= tally_r;
            state_snap_r <= last_state_r;
            x_snap_r     <= x;
         end else begin
            tally_snap_r <= tally_snap_r;
            state_snap_r <= state_snap_r;
            x_snap_r     <= x_snap_r;
         end
      end
   end

   // On the rising cycle the live values equal what is being captured, so live is shown
   always_comb begin
      disp_tally_s = tally_r;
      disp_state_s = last_state_r;
      disp_x_s     = x;
      if (hold & hold_d_r) begin
         disp_tally_s = tally_snap_r;
         disp_state_s = state_snap_r;
         disp_x_s     = x_snap_r;
      end else begin
         disp_tally_s = tally_r;
         disp_state_s = last_state_r;
         disp_x_s     = x;
      end
   end
`else
   assign disp_tally_s = tally_r;
   assign disp_state_s = last_state_r;
   assign disp_x_s     = x;
`endif

   // Select the nibble for the digit currently being scanned
   always_comb begin
      digit_s = 4'h0;
      case (idx_r)
         2'd0:    digit_s = disp_tally_s[3:0];
         2'd1:    digit_s = disp_tally_s[7:4];
         2'd2:    digit_s = disp_state_s;
         2'd3:    digit_s = {3'b000, disp_x_s};
         default: digit_s = 4'h0;
      endcase
   end

   hex_to_seg u_hex_to_seg (
      .val (digit_s),
      .seg (dec_seg_s)
   );

   // Prescaler, digit index and registered anode/segment drive
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         presc_r <= 16'd0;
         idx_r   <= 2'd0;
         seg_r   <= SEG_BLANK;
         an_r    <= AN_OFF;
      end else begin
         if (presc_r == SCAN_TERM) begin
            presc_r <= 16'd0;
            idx_r   <= idx_r + 2'd1;
         end else begin
            presc_r <= presc_r + 16'd1;
            idx_r   <= idx_r;
         end
         an_r  <= ~(4'b0001 << idx_r);
         seg_r <= dec_seg_s;
      end
   end

   assign tally       = tally_r;
   assign last_state  = last_state_r;
   assign event_pulse = event_pulse_r;
   assign seg         = seg_r;
   assign an          = an_r;

endmodule

// File: tb/tb_two_four_monitor.sv
// Scoreboard bench for two_four_monitor: stimulus pushes expected events and scan digits,
// independent monitors pop and compare on event_pulse and on anode changes.
module tb_two_four_monitor;

   typedef struct {
      logic [7:0] t;
      logic [3:0] s;
      int         c;
   } ev_t;

   typedef struct {
      logic [3:0] an;
      logic [6:0] seg;
   } scan_t;

   logic       clk;
   logic       rst_n;
   logic [3:0] st;
   logic       x;
   logic       z;
   logic       clr;
   logic       hold;
   logic [7:0] tally;
   logic [3:0] last_state;
   logic       event_pulse;
   logic [6:0] seg;
   logic [3:0] an;

   int    total;
   int    bad;
   int    cyc;
   int    count;
   int    pulse_cnt;
   ev_t   evq[$];
   scan_t scanq[$];
   bit    scan_en;
   logic  prev_pulse;
   logic [3:0] cur_an;
   int    run_len;
   bit    started;

   two_four_monitor #(.SCAN_DIV(4)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .a           (st[3]),
      .b           (st[2]),
      .c           (st[1]),
      .d           (st[0]),
      .x           (x),
      .z           (z),
      .clr         (clr),
`ifdef TWO_FOUR_MONITOR_HOLD_EN
      .hold        (hold),
`endif
      .tally       (tally),
      .last_state  (last_state),
      .event_pulse (event_pulse),
      .seg         (seg),
      .an          (an)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      cyc = 0;
      forever begin
         @(posedge clk);
         cyc = cyc + 1;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total = total + 1;
      if (act !== exp) begin
         bad = bad + 1;
         $display("FAIL %s actual=%h expected=%h at t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] to_bcd(input int n);
      return {4'(n / 10), 4'(n % 10)};
   endfunction

   // One z event: called #1 after a posedge with z low for at least one sampled cycle
   task automatic ev(input int hi, input int lo);
      ev_t e;
      count = (count + 1) % 100;
      e.t = to_bcd(count);
      e.s = st;
      e.c = cyc + 1;
      evq.push_back(e);
      z = 1'b1;
      repeat (hi) @(posedge clk);
      #1 z = 1'b0;
      repeat (lo) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      z     = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      count = 0;
      @(posedge clk);
      #1;
   endtask

   // Event monitor
   initial begin
      prev_pulse = 1'b0;
      forever begin
         @(negedge clk);
         if (event_pulse === 1'b1) begin
            ev_t e;
            pulse_cnt = pulse_cnt + 1;
            chk("pulse_single", {31'd0, prev_pulse}, 32'd0);
            chk("pulse_expected", {31'd0, evq.size() != 0}, 32'd1);
            if (evq.size() != 0) begin
               e = evq.pop_front();
               chk("ev_tally", {24'd0, tally}, {24'd0, e.t});
               chk("ev_last_state", {28'd0, last_state}, {28'd0, e.s});
               chk("ev_cycle", cyc, e.c);
            end
         end
         prev_pulse = (event_pulse === 1'b1);
      end
   end

   // Scan monitor
   initial begin
      forever begin
         @(negedge clk);
         if (!scan_en) begin
            cur_an  = an;
            started = 1'b0;
            run_len = 0;
         end else if (an !== cur_an) begin
            if (started) begin
               chk("scan_run_len", run_len, 4);
            end
            if (scanq.size() != 0) begin
               scan_t s;
               s = scanq.pop_front();
               chk("scan_an", {28'd0, an}, {28'd0, s.an});
               chk("scan_seg", {25'd0, seg}, {25'd0, s.seg});
            end
            started = 1'b1;
            run_len = 1;
            cur_an  = an;
         end else begin
            run_len = run_len + 1;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      bit found;
      total = 0; bad = 0; count = 0; pulse_cnt = 0;
      scan_en = 1'b0;
      rst_n = 1'b0; z = 1'b1; clr = 1'b0; hold = 1'b0; st = 4'h0; x = 1'b0;

      // 1: reset with z high, release with z still high
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_seg", {25'd0, seg}, 32'h7F);
      chk("rst_an", {28'd0, an}, 32'hF);
      chk("rst_tally", {24'd0, tally}, 32'h00);
      chk("rst_pulse", {31'd0, event_pulse}, 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("first_an", {28'd0, an}, 32'hE);
      chk("first_seg", {25'd0, seg}, 32'h40);
      repeat (3) @(posedge clk);
      #1 z = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("no_count_on_release", {24'd0, tally}, 32'h00);
      chk("no_pulse_on_release", pulse_cnt, 0);

      // 2: twelve single-cycle pulses with state 1010
      st = 4'hA;
      for (int i = 0; i < 12; i++) ev(1, 3);
      repeat (2) @(posedge clk);
      #1;
      chk("t2_tally", {24'd0, tally}, 32'h12);
      chk("t2_last_state", {28'd0, last_state}, 32'hA);
      chk("t2_pulses", pulse_cnt, 12);

      // 3: z held high for 10 cycles counts once
      st = 4'h3;
      ev(10, 3);
      chk("t3_tally", {24'd0, tally}, 32'h13);
      chk("t3_pulses", pulse_cnt, 13);

      // 4: 100 events from reset wrap 99 -> 00
      do_reset();
      for (int i = 0; i < 100; i++) begin
         st = 4'(i);
         ev(1, 1);
      end
      chk("t4_wrap", {24'd0, tally}, 32'h00);

      // 5: clr coincident with a z rise at tally 05
      st = 4'h9;
      for (int i = 0; i < 5; i++) ev(1, 1);
      chk("t5_pre", {24'd0, tally}, 32'h05);
      clr = 1'b1; z = 1'b1;
      @(posedge clk);
      #1 clr = 1'b0; z = 1'b0;
      count = 0;
      chk("t5_clr_tally", {24'd0, tally}, 32'h00);
      chk("t5_clr_state", {28'd0, last_state}, 32'h0);
      chk("t5_clr_pulse", {31'd0, event_pulse}, 32'd0);
      @(posedge clk);
      #1;
      st = 4'h5;
      ev(1, 1);
      chk("t5_after", {24'd0, tally}, 32'h01);

      // 6: display scan with tally 37, last_state 5, x 1
      x = 1'b1;
      for (int i = 0; i < 36; i++) ev(1, 1);
      chk("t6_tally", {24'd0, tally}, 32'h37);
      repeat (3) @(posedge clk);
      scanq.push_back('{4'b1110, 7'h78});
      scanq.push_back('{4'b1101, 7'h30});
      scanq.push_back('{4'b1011, 7'h12});
      scanq.push_back('{4'b0111, 7'h79});
      scanq.push_back('{4'b1110, 7'h78});
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         @(negedge clk);
         if (an === 4'b0111) found = 1'b1;
      end
      chk("scan_sync", {31'd0, found}, 32'd1);
      #1 scan_en = 1'b1;
      for (int i = 0; i < 60 && scanq.size() != 0; i++) @(posedge clk);
      chk("scan_drained", scanq.size(), 0);
      scan_en = 1'b0;

      repeat (4) @(posedge clk);
      chk("evq_empty", evq.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
